// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake game encodings, start position and coordinate widths
package snake_pkg;

  localparam int X_W = 6;
  localparam int Y_W = 5;

  localparam logic [X_W-1:0] START_X = 6'd20;
  localparam logic [Y_W-1:0] START_Y = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DIE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - game controller signal bundle; master drives buttons/events, slave is the controller
interface snake_game_ctrl_if;
  import snake_pkg::*;

  logic           btn_start;
  logic [3:0]     dir_req;
  logic           eat;
  logic           self_hit;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic           move_tick;
  logic [1:0]     game_state;
  logic [1:0]     direction;
  logic [4:0]     snake_len;
  logic [7:0]     score;

  modport master (
    output btn_start, dir_req, eat, self_hit,
    input  head_x, head_y, move_tick, game_state, direction, snake_len, score
  );

  modport slave (
    input  btn_start, dir_req, eat, self_hit,
    output head_x, head_y, move_tick, game_state, direction, snake_len, score
  );

endinterface

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - movement step divider; SNAKE_SPEEDUP_EN shortens the period on each eat
module snake_tick_gen
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic eat_ok,
  output logic step
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_act;

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] DEC   = CNT_W'(TICK_DIV / 16);
  localparam logic [CNT_W-1:0] FLOOR = CNT_W'(TICK_DIV / 4);

  logic [CNT_W-1:0] period_next;

  // period_next collects eats; the running period only picks it up at a wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      period_next <= CNT_W'(TICK_DIV);
      period_act  <= CNT_W'(TICK_DIV);
    end else begin
      if (eat_ok)
        period_next <= (period_next >= FLOOR + DEC) ? period_next - DEC : FLOOR;
      if (step)
        period_act <= period_next;
    end
  end
`else
  logic unused_eat_ok;
  assign unused_eat_ok = eat_ok;
  assign period_act    = CNT_W'(TICK_DIV);
`endif

  assign step = en && (cnt == period_act - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (en)
      cnt <= step ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: IDLE/PLAY/DIE, head position, direction, length, score
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 250000,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int INIT_LEN   = 3,
  parameter int MAX_LEN    = 16,
  parameter int DIE_CYCLES = 25000000
) (
  input logic              clk,
  input logic              reset,
  snake_game_ctrl_if.slave bus
);

  localparam int DIE_W = $clog2(DIE_CYCLES + 1);

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d, pend_q, pend_d, req_dir;
  logic [X_W-1:0]    hx_q, hx_d, nx;
  logic [Y_W-1:0]    hy_q, hy_d, ny;
  logic [4:0]        len_q, len_d;
  logic [7:0]        score_q, score_d;
  logic [DIE_W-1:0]  die_q, die_d;
  logic              move_q, move_d;
  logic              btn_prev_q;
  logic              start_edge, play_entry, in_play, step, wall, death, eat_ok, req_ok;

  assign in_play    = (state_q == ST_PLAY);
  assign start_edge = bus.btn_start & ~btn_prev_q;
  assign play_entry = (state_q == ST_IDLE) && start_edge;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (in_play),
    .clear  (play_entry),
    .eat_ok (eat_ok),
    .step   (step)
  );

  // Candidate head follows pending, which becomes the committed direction on the step.
  always_comb begin
    nx = hx_q;
    ny = hy_q;
    case (pend_q)
      DIR_UP:    ny = hy_q - Y_W'(1);
      DIR_DOWN:  ny = hy_q + Y_W'(1);
      DIR_LEFT:  nx = hx_q - X_W'(1);
      default:   nx = hx_q + X_W'(1);
    endcase
  end

  assign wall   = (nx == '0) || (nx == X_W'(GRID_W - 1)) ||
                  (ny == '0) || (ny == Y_W'(GRID_H - 1));
  assign death  = in_play && (bus.self_hit || (step && wall));
  assign eat_ok = in_play && bus.eat && !death;

  always_comb begin
    req_ok  = 1'b0;
    req_dir = DIR_RIGHT;
    case (bus.dir_req)
      4'b1000: begin req_ok = 1'b1; req_dir = DIR_UP;    end
      4'b0100: begin req_ok = 1'b1; req_dir = DIR_DOWN;  end
      4'b0010: begin req_ok = 1'b1; req_dir = DIR_LEFT;  end
      4'b0001: begin req_ok = 1'b1; req_dir = DIR_RIGHT; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    len_d   = len_q;
    score_d = score_q;
    die_d   = die_q;
    move_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_PLAY;
          hx_d    = START_X;
          hy_d    = START_Y;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
          len_d   = 5'(INIT_LEN);
          score_d = '0;
        end
      end
      ST_PLAY: begin
        // Reversal is judged against the committed direction so two fast presses cannot U-turn.
        if (req_ok && (req_dir != opposite(dir_q)))
          pend_d = req_dir;
        if (death) begin
          state_d = ST_DIE;
        end else if (step) begin
          dir_d  = pend_q;
          hx_d   = nx;
          hy_d   = ny;
          move_d = 1'b1;
        end
        if (eat_ok) begin
          if (len_q < 5'(MAX_LEN))
            len_d = len_q + 5'd1;
          if (score_q != 8'hFF)
            score_d = score_q + 8'd1;
        end
      end
      ST_DIE: begin
        if (die_q == DIE_W'(DIE_CYCLES - 1)) begin
          state_d = ST_IDLE;
          die_d   = '0;
        end else begin
          die_d = die_q + DIE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hx_q       <= START_X;
      hy_q       <= START_Y;
      dir_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      len_q      <= 5'(INIT_LEN);
      score_q    <= '0;
      die_q      <= '0;
      move_q     <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      len_q      <= len_d;
      score_q    <= score_d;
      die_q      <= die_d;
      move_q     <= move_d;
      btn_prev_q <= bus.btn_start;
    end
  end

  assign bus.head_x     = hx_q;
  assign bus.head_y     = hy_q;
  assign bus.move_tick  = move_q;
  assign bus.game_state = state_q;
  assign bus.direction  = dir_q;
  assign bus.snake_len  = len_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - self-checking bench for snake_game_ctrl with a head-position scoreboard
module tb_snake_game_ctrl;
  import snake_pkg::*;

  localparam int TD = 4;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .TICK_DIV(TD), .GRID_W(40), .GRID_H(30),
    .INIT_LEN(3), .MAX_LEN(16), .DIE_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [5:0] x;
    logic [4:0] y;
    logic [1:0] dir;
  } vec_t;

  typedef struct {
    logic [5:0] x;
    logic [4:0] y;
  } pos_t;

  vec_t vecs [6];
  pos_t exp_q [$];
  pos_t mon_p;
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y);
    pos_t p;
    p.x = 6'(x);
    p.y = 5'(y);
    exp_q.push_back(p);
  endtask

  task automatic wait_move(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      cyc();
      if (bus.move_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      failed++;
      $display("FAIL %s: no move_tick within %0d cycles", name, 3 * TD);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 4 * DC; i++) begin
      cyc();
      if (bus.game_state === st) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got) begin
      failed++;
      $display("FAIL %s: game_state %0d never reached %0d", name, bus.game_state, st);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_head_x"},    bus.head_x,     20);
    chk({tag, "_head_y"},    bus.head_y,     15);
    chk({tag, "_move_tick"}, bus.move_tick,  0);
    chk({tag, "_state"},     bus.game_state, 0);
    chk({tag, "_direction"}, bus.direction,  3);
    chk({tag, "_len"},       bus.snake_len,  3);
    chk({tag, "_score"},     bus.score,      0);
  endtask

  // Every move_tick must match the next head the stimulus predicted.
  always @(posedge clk) begin
    #1;
    if (bus.move_tick === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_move: head (%0d,%0d) with no move expected", bus.head_x, bus.head_y);
      end else begin
        mon_p = exp_q.pop_front();
        if (bus.head_x !== mon_p.x || bus.head_y !== mon_p.y) begin
          failed++;
          $display("FAIL move_head: got (%0d,%0d), expected (%0d,%0d)",
                   bus.head_x, bus.head_y, mon_p.x, mon_p.y);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.btn_start = 1'b0;
    bus.dir_req   = 4'b0000;
    bus.eat       = 1'b0;
    bus.self_hit  = 1'b0;

    vecs[0] = '{4'b0010, 6'd22, 5'd15, 2'd3};
    vecs[1] = '{4'b1000, 6'd22, 5'd14, 2'd0};
    vecs[2] = '{4'b1001, 6'd22, 5'd13, 2'd0};
    vecs[3] = '{4'b0100, 6'd22, 5'd12, 2'd0};
    vecs[4] = '{4'b0001, 6'd23, 5'd12, 2'd3};
    vecs[5] = '{4'b1100, 6'd24, 5'd12, 2'd3};

    repeat (2) cyc();
    chk_reset("reset");
    reset = 1'b0;

    // Game A: start timing, direction handling, self-hit, DIE timing
    push(21, 15);
    bus.btn_start = 1'b1;
    cyc();
    chk("start_state", bus.game_state, 1);
    chk("start_head_x", bus.head_x, 20);
    chk("start_head_y", bus.head_y, 15);
    for (int i = 1; i < TD; i++) begin
      cyc();
      chk("no_early_move", bus.move_tick, 0);
      chk("held_start_play", bus.game_state, 1);
    end
    cyc();
    chk("first_move_tick", bus.move_tick, 1);
    chk("first_move_x", bus.head_x, 21);
    bus.btn_start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      bus.dir_req = vecs[i].req;
      push(int'(vecs[i].x), int'(vecs[i].y));
      cyc();
      bus.dir_req = 4'b0000;
      wait_move("vec_move");
      chk("vec_dir", bus.direction, vecs[i].dir);
    end

    // up then left while committed right: left must be rejected
    push(24, 11);
    bus.dir_req = 4'b1000;
    cyc();
    bus.dir_req = 4'b0010;
    cyc();
    bus.dir_req = 4'b0000;
    wait_move("quick_move");
    chk("quick_dir", bus.direction, 0);

    bus.self_hit = 1'b1;
    cyc();
    bus.self_hit = 1'b0;
    chk("selfhit_state", bus.game_state, 2);
    chk("selfhit_head_x", bus.head_x, 24);
    chk("selfhit_head_y", bus.head_y, 11);
    chk("selfhit_move", bus.move_tick, 0);
    bus.btn_start = 1'b1;
    cyc();
    chk("die_ignores_start", bus.game_state, 2);
    bus.btn_start = 1'b0;
    repeat (DC - 2) cyc();
    chk("die_last_cycle", bus.game_state, 2);
    cyc();
    chk("die_to_idle", bus.game_state, 0);

    bus.eat      = 1'b1;
    bus.self_hit = 1'b1;
    bus.dir_req  = 4'b0001;
    cyc();
    bus.eat      = 1'b0;
    bus.self_hit = 1'b0;
    bus.dir_req  = 4'b0000;
    chk("idle_ignore_state", bus.game_state, 0);
    chk("idle_ignore_len", bus.snake_len, 3);
    chk("idle_ignore_score", bus.score, 0);
    chk("idle_hold_x", bus.head_x, 24);

    // Game B: eats with saturation, eat alongside steps, death beats eat
    for (int k = 1; k <= 5; k++) push(20 + k, 15);
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    chk("b_state", bus.game_state, 1);
    bus.eat = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cyc();
      if (k == 2) begin
        chk("two_eats_len", bus.snake_len, 5);
        chk("two_eats_score", bus.score, 2);
      end
    end
    chk("sat_len", bus.snake_len, 16);
    chk("many_eats_score", bus.score, 22);
    bus.self_hit = 1'b1;
    cyc();
    bus.eat      = 1'b0;
    bus.self_hit = 1'b0;
    chk("eat_hit_state", bus.game_state, 2);
    chk("eat_hit_score", bus.score, 22);
    chk("eat_hit_len", bus.snake_len, 16);
    chk("eat_hit_head_x", bus.head_x, 25);
    wait_state(2'b00, "b_back_to_idle");

    // Game C: fresh start resets score/len, then run into the right wall
    for (int k = 21; k <= 38; k++) push(k, 15);
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    chk("c_state", bus.game_state, 1);
    chk("c_score", bus.score, 0);
    chk("c_len", bus.snake_len, 3);
    for (int k = 0; k < 18; k++) wait_move("wall_run_move");
    chk("wall_run_x", bus.head_x, 38);
    repeat (TD - 1) cyc();
    chk("pre_wall_play", bus.game_state, 1);
    cyc();
    chk("wall_state", bus.game_state, 2);
    chk("wall_head_x", bus.head_x, 38);
    chk("wall_move", bus.move_tick, 0);
    repeat (DC - 1) cyc();
    chk("wall_die_hold", bus.game_state, 2);
    cyc();
    chk("wall_die_idle", bus.game_state, 0);

    // Game D: reset in the middle of PLAY
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
    chk("d_state", bus.game_state, 1);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk_reset("midreset");
    reset = 1'b0;
    repeat (2 * TD) cyc();
    chk("post_reset_idle", bus.game_state, 0);

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL pending_moves: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
